// File: rtl/sv32_page_table_walker_pkg.sv
// Sv32 page-table walker shared types.
// States, PTE layout, widths and PTE address helper.
package sv32_page_table_walker_pkg;

  localparam int PA_WD  = 34;
  localparam int PTE_WD = 32;
  localparam int ASID_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    DONE,
    ABORT
  } ptw_state_e;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } sv32_pte_t;

  // Table base plus 4-byte index; low 12 bits of base are zero.
  function automatic logic [PA_WD-1:0] pte_addr(
    input logic [21:0] ppn,
    input logic [9:0]  idx
  );
    return {ppn, 12'h0} + {22'h0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_page_table_walker_if.sv
// Sv32 walker bus bundle.
// TLB miss, PTE memory port and TLB refill handshakes.
interface sv32_page_table_walker_if;
  import sv32_page_table_walker_pkg::*;

  logic              miss_valid;
  logic              miss_ready;
  logic [19:0]       miss_vpn;
  logic [ASID_W-1:0] miss_asid;
  logic [21:0]       satp_ppn;
  logic              flush;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PA_WD-1:0]  mem_req_addr;
  logic              mem_rsp_valid;
  logic [PTE_WD-1:0] mem_rsp_data;

  logic              refill_valid;
  logic              refill_ready;
  logic [19:0]       refill_vpn;
  logic [ASID_W-1:0] refill_asid;
  logic [21:0]       refill_ppn;
  logic [7:0]        refill_perm;
  logic              refill_super;
  logic              refill_fault;

  modport slave (
    input  miss_valid, miss_vpn, miss_asid,
    input  satp_ppn, flush,
    output miss_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output refill_valid, refill_vpn,
    output refill_asid, refill_ppn,
    output refill_perm, refill_super,
    output refill_fault,
    input  refill_ready
  );

  modport master (
    output miss_valid, miss_vpn, miss_asid,
    output satp_ppn, flush,
    input  miss_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  refill_valid, refill_vpn,
    input  refill_asid, refill_ppn,
    input  refill_perm, refill_super,
    input  refill_fault,
    output refill_ready
  );

endinterface

// File: rtl/sv32_pte_check.sv
// Sv32 PTE classifier.
// Flags leaf PTEs and every page-fault condition per level.
module sv32_pte_check
  import sv32_page_table_walker_pkg::*;
(
  input  sv32_pte_t pte,
  input  logic      level,
  output logic      is_leaf,
  output logic      is_fault
);

  logic bad;
  logic unused_bits;

  assign unused_bits = ^{pte.ppn1, pte.rsw,
                         pte.d, pte.g, pte.u};

  // Level 1 leaf must be 4 MiB aligned; level 0 must be a leaf.
  always_comb begin
    is_leaf  = pte.r | pte.x;
    bad      = ~pte.v
             | (~pte.r & pte.w)
             | (is_leaf & ~pte.a);
    is_fault = bad
             | (level ? (is_leaf & (pte.ppn0 != '0))
                      : ~is_leaf);
  end

endmodule

// File: rtl/sv32_page_table_walker.sv
// Sv32 two-level page-table walker.
// One walk in flight; flush aborts, absorbing any pending read.
module sv32_page_table_walker
  import sv32_page_table_walker_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  sv32_page_table_walker_if.slave  bus
);

  ptw_state_e        state_q;
  ptw_state_e        state_d;
  logic [19:0]       vpn_q;
  logic [ASID_W-1:0] asid_q;
  logic [PA_WD-1:0]  addr_q;
  logic [21:0]       ppn_q;
  logic [7:0]        perm_q;
  logic              super_q;
  logic              fault_q;

  sv32_pte_t pte;
  logic      lvl1;
  logic      leaf;
  logic      bad;
  logic      accept;
  logic      rsp_l1;
  logic      rsp_l0;
  logic      ptr;
  logic      last;

  assign pte    = sv32_pte_t'(bus.mem_rsp_data);
  assign lvl1   = (state_q == L1_WAIT);
  assign accept = (state_q == IDLE)
                & bus.miss_valid & ~bus.flush;
  assign rsp_l1 = lvl1 & bus.mem_rsp_valid
                & ~bus.flush;
  assign rsp_l0 = (state_q == L0_WAIT)
                & bus.mem_rsp_valid & ~bus.flush;
  assign ptr    = rsp_l1 & ~leaf & ~bad;
  assign last   = (rsp_l1 | rsp_l0) & ~ptr;

  sv32_pte_check u_chk (
    .pte      (pte),
    .level    (lvl1),
    .is_leaf  (leaf),
    .is_fault (bad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = L1_REQ;
      L1_REQ:
        unique case (1'b1)
          bus.flush:         state_d = IDLE;
          bus.mem_req_ready: state_d = L1_WAIT;
          default:           state_d = L1_REQ;
        endcase
      L0_REQ:
        unique case (1'b1)
          bus.flush:         state_d = IDLE;
          bus.mem_req_ready: state_d = L0_WAIT;
          default:           state_d = L0_REQ;
        endcase
      L1_WAIT, L0_WAIT:
        unique case (1'b1)
          bus.flush & bus.mem_rsp_valid: state_d = IDLE;
          bus.flush:                     state_d = ABORT;
          ptr:                           state_d = L0_REQ;
          last:                          state_d = DONE;
          default:                       state_d = state_q;
        endcase
      DONE:
        if (bus.flush | bus.refill_ready)
          state_d = IDLE;
      ABORT:
        if (bus.mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk context, PTE address and leaf result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpn_q   <= '0;
      asid_q  <= '0;
      addr_q  <= '0;
      ppn_q   <= '0;
      perm_q  <= '0;
      super_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        vpn_q  <= bus.miss_vpn;
        asid_q <= bus.miss_asid;
        addr_q <= pte_addr(bus.satp_ppn,
                           bus.miss_vpn[19:10]);
      end
      if (ptr)
        addr_q <= pte_addr({pte.ppn1, pte.ppn0},
                           vpn_q[9:0]);
      if (last) begin
        ppn_q   <= {pte.ppn1, pte.ppn0};
        perm_q  <= bus.mem_rsp_data[7:0];
        super_q <= lvl1;
        fault_q <= bad;
      end
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.miss_ready    = (state_q == IDLE) & ~bus.flush;
    bus.mem_req_valid = (state_q == L1_REQ)
                      | (state_q == L0_REQ);
    bus.refill_valid  = (state_q == DONE);
  end

  assign bus.mem_req_addr = addr_q;
  assign bus.refill_vpn   = vpn_q;
  assign bus.refill_asid  = asid_q;
  assign bus.refill_ppn   = ppn_q;
  assign bus.refill_perm  = perm_q;
  assign bus.refill_super = super_q;
  assign bus.refill_fault = fault_q;

  a_rsp_in_wait: assert property (
    @(posedge clk) disable iff (!rst)
    bus.mem_rsp_valid |->
      (state_q inside {L1_WAIT, L0_WAIT, ABORT})
  ) else $error("mem_rsp_valid with no read pending");

endmodule

// File: tb/tb_sv32_page_table_walker.sv
// Directed bench for sv32_page_table_walker.
// Memory responder serves PTEs by address; vectors hand-computed.
module tb_sv32_page_table_walker;
  import sv32_page_table_walker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sv32_page_table_walker_if bus ();

  sv32_page_table_walker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;
  int nreq   = 0;
  int rsp_delay = 0;
  logic [33:0] req_log [256];
  logic [31:0] pte1 = '0;
  logic [31:0] pte0 = '0;
  logic [33:0] l1a  = '0;
  logic [31:0] rsp_d;

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: reply rsp_delay cycles after each accepted read.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        req_log[nreq[7:0]] = bus.mem_req_addr;
        rsp_d = (bus.mem_req_addr == l1a) ? pte1 : pte0;
        nreq++;
        @(posedge clk);
        repeat (rsp_delay) @(posedge clk);
        #1;
        bus.mem_rsp_data  = rsp_d;
        bus.mem_rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic start_miss(logic [19:0] vpn,
                            logic [8:0]  asid,
                            logic [21:0] satp);
    l1a = {satp, 12'h0} + {22'h0, vpn[19:10], 2'b00};
    bus.miss_valid = 1'b1;
    bus.miss_vpn   = vpn;
    bus.miss_asid  = asid;
    bus.satp_ppn   = satp;
    tick();
    bus.miss_valid = 1'b0;
  endtask

  task automatic wait_refill(output int n);
    n = 0;
    while (!bus.refill_valid && n < 60) begin
      tick();
      n++;
    end
    chk("refill_seen", {63'h0, bus.refill_valid}, 1);
  endtask

  task automatic walk(string tag,
                      logic [19:0] vpn,
                      logic [8:0]  asid,
                      logic [21:0] satp,
                      logic [31:0] p1,
                      logic [31:0] p0,
                      logic [21:0] e_ppn,
                      logic [7:0]  e_perm,
                      logic        e_sup,
                      logic        e_flt,
                      int          e_nreq);
    int base;
    int n;
    logic [33:0] l0a;
    pte1 = p1;
    pte0 = p0;
    l0a  = {p1[31:10], 12'h0} + {22'h0, vpn[9:0], 2'b00};
    base = nreq;
    chk({tag, "_mready"}, {63'h0, bus.miss_ready}, 1);
    start_miss(vpn, asid, satp);
    chk({tag, "_reqv"}, {63'h0, bus.mem_req_valid}, 1);
    chk({tag, "_l1a"}, {30'h0, bus.mem_req_addr},
        {30'h0, l1a});
    wait_refill(n);
    chk({tag, "_lat"}, n, e_nreq * 2);
    chk({tag, "_vpn"}, {44'h0, bus.refill_vpn}, {44'h0, vpn});
    chk({tag, "_asid"}, {55'h0, bus.refill_asid},
        {55'h0, asid});
    chk({tag, "_fault"}, {63'h0, bus.refill_fault},
        {63'h0, e_flt});
    if (!e_flt) begin
      chk({tag, "_ppn"}, {42'h0, bus.refill_ppn},
          {42'h0, e_ppn});
      chk({tag, "_perm"}, {56'h0, bus.refill_perm},
          {56'h0, e_perm});
      chk({tag, "_super"}, {63'h0, bus.refill_super},
          {63'h0, e_sup});
    end
    chk({tag, "_nreq"}, nreq - base, e_nreq);
    chk({tag, "_log1"}, {30'h0, req_log[base]},
        {30'h0, l1a});
    if (e_nreq == 2)
      chk({tag, "_log0"}, {30'h0, req_log[base + 1]},
          {30'h0, l0a});
    tick();
    chk({tag, "_drop"}, {63'h0, bus.refill_valid}, 0);
    chk({tag, "_b2b"}, {63'h0, bus.miss_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic prev;
    bus.miss_valid    = 1'b0;
    bus.miss_vpn      = '0;
    bus.miss_asid     = '0;
    bus.satp_ppn      = '0;
    bus.flush         = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.refill_ready  = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_mready", {63'h0, bus.miss_ready}, 1);
    chk("rst_reqv", {63'h0, bus.mem_req_valid}, 0);
    chk("rst_refv", {63'h0, bus.refill_valid}, 0);
    chk("rst_ppn", {42'h0, bus.refill_ppn}, 0);
    rst = 1'b1;
    tick();

    walk("two_lvl", 20'h12345, 9'h005, 22'h00010,
         32'h00040001, 32'h123450CF,
         22'h048D14, 8'hCF, 1'b0, 1'b0, 2);
    walk("super", 20'h12345, 9'h006, 22'h00010,
         32'h3000004F, 32'h0,
         22'h0C0000, 8'h4F, 1'b1, 1'b0, 1);
    walk("misalign", 20'h12345, 9'h007, 22'h00010,
         32'h3000044F, 32'h0,
         22'h0, 8'h0, 1'b0, 1'b1, 1);
    walk("w_no_r", 20'h00400, 9'h008, 22'h00020,
         32'h00000045, 32'h0,
         22'h0, 8'h0, 1'b0, 1'b1, 1);
    walk("inval", 20'h00401, 9'h009, 22'h00020,
         32'h00000000, 32'h0,
         22'h0, 8'h0, 1'b0, 1'b1, 1);
    walk("l0_ptr", 20'h12345, 9'h00A, 22'h00010,
         32'h00040001, 32'h00050001,
         22'h0, 8'h0, 1'b0, 1'b1, 2);
    walk("l0_noA", 20'h12345, 9'h00B, 22'h00010,
         32'h00040001, 32'h1234508F,
         22'h0, 8'h0, 1'b0, 1'b1, 2);
    walk("top_addr", 20'hFFFFF, 9'h1FF, 22'h3FFFFE,
         32'hFFFFFC01, 32'hABCDE4C3,
         22'h2AF379, 8'hC3, 1'b0, 1'b0, 2);

    // Request and refill back-pressure.
    pte1 = 32'h00040001;
    pte0 = 32'h123450CF;
    base = nreq;
    bus.mem_req_ready = 1'b0;
    start_miss(20'h12345, 9'h005, 22'h00010);
    for (int i = 0; i < 5; i++) begin
      chk("stall_reqv", {63'h0, bus.mem_req_valid}, 1);
      chk("stall_addr", {30'h0, bus.mem_req_addr},
          64'h10120);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    bus.refill_ready  = 1'b0;
    wait_refill(n);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {63'h0, bus.refill_valid}, 1);
      chk("hold_ppn", {42'h0, bus.refill_ppn}, 64'h048D14);
      chk("hold_perm", {56'h0, bus.refill_perm}, 64'hCF);
      tick();
    end
    bus.refill_ready = 1'b1;
    tick();
    chk("hold_done", {63'h0, bus.refill_valid}, 0);
    chk("stall_nreq", nreq - base, 2);

    // Flush while the level-1 read is outstanding.
    rsp_delay = 4;
    base = nreq;
    start_miss(20'h12345, 9'h005, 22'h00010);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    prev = 1'b0;
    n = 0;
    while (!bus.miss_ready && n < 20) begin
      chk("abort_refv", {63'h0, bus.refill_valid}, 0);
      chk("abort_reqv", {63'h0, bus.mem_req_valid}, 0);
      prev = bus.mem_rsp_valid;
      tick();
      n++;
    end
    chk("abort_idle", {63'h0, bus.miss_ready}, 1);
    chk("abort_after_rsp", {63'h0, prev}, 1);
    chk("abort_nreq", nreq - base, 1);
    tick();
    chk("abort_norefill", {63'h0, bus.refill_valid}, 0);
    rsp_delay = 0;

    // Flush in L1_REQ before the request is taken.
    base = nreq;
    bus.mem_req_ready = 1'b0;
    start_miss(20'h12345, 9'h005, 22'h00010);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("freq_reqv", {63'h0, bus.mem_req_valid}, 0);
    chk("freq_mready", {63'h0, bus.miss_ready}, 1);
    bus.mem_req_ready = 1'b1;
    tick();
    chk("freq_nreq", nreq - base, 0);

    // Flush in IDLE blocks a simultaneous miss.
    bus.flush      = 1'b1;
    bus.miss_valid = 1'b1;
    #1;
    chk("fidle_mready", {63'h0, bus.miss_ready}, 0);
    tick();
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    #1;
    chk("fidle_reqv", {63'h0, bus.mem_req_valid}, 0);
    chk("fidle_mready2", {63'h0, bus.miss_ready}, 1);

    // Flush in DONE drops the refill.
    pte1 = 32'h3000004F;
    bus.refill_ready = 1'b0;
    start_miss(20'h12345, 9'h006, 22'h00010);
    wait_refill(n);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fdone_refv", {63'h0, bus.refill_valid}, 0);
    chk("fdone_mready", {63'h0, bus.miss_ready}, 1);
    bus.refill_ready = 1'b1;
    tick();

    // Async reset while waiting for the level-0 PTE.
    rsp_delay = 3;
    pte1 = 32'h00040001;
    pte0 = 32'h123450CF;
    base = nreq;
    start_miss(20'h12345, 9'h0AB, 22'h00010);
    n = 0;
    while (nreq < base + 2 && n < 40) begin
      tick();
      n++;
    end
    chk("rmid_l0req", nreq - base, 2);
    rst = 1'b0;
    #1;
    chk("rmid_mready", {63'h0, bus.miss_ready}, 1);
    chk("rmid_reqv", {63'h0, bus.mem_req_valid}, 0);
    chk("rmid_refv", {63'h0, bus.refill_valid}, 0);
    chk("rmid_vpn", {44'h0, bus.refill_vpn}, 0);
    chk("rmid_asid", {55'h0, bus.refill_asid}, 0);
    chk("rmid_addr", {30'h0, bus.mem_req_addr}, 0);
    repeat (6) tick();
    rst = 1'b1;
    rsp_delay = 0;
    tick();
    chk("rmid_stay", {63'h0, bus.refill_valid}, 0);

    walk("recover", 20'h12345, 9'h005, 22'h00010,
         32'h00040001, 32'h123450CF,
         22'h048D14, 8'hCF, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
